// File: rtl/sched_controller.sv
// Interrupt/context scheduler: vectors, preemption timer, event arbitration,
// one-cycle PC redirect, saved-PC return and PC capture.
// Ports: clk, reset (sync, active-high); SCHED_conf/SCHED_OP/SCHED_value op
// strobe; PC_pos, cpu_ready, syscall_req, dma_irq in; jump, jump_addr,
// in_handler, pc_out, pc_out_valid out (all registered).
// Define SCHED_DMA_INT_EN to implement the DMA event source.
module sched_controller #(
  parameter logic [15:0] DEFAULT_QUANTUM = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCHED_conf,
  input  logic [3:0]  SCHED_OP,
  input  logic [15:0] SCHED_value,
  input  logic [15:0] PC_pos,
  input  logic        cpu_ready,
  input  logic        syscall_req,
  input  logic        dma_irq,
  output logic        jump,
  output logic [15:0] jump_addr,
  output logic        in_handler,
  output logic [15:0] pc_out,
  output logic        pc_out_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sys_vec_q, sys_vec_d;
  logic [15:0] tmr_vec_q, tmr_vec_d;
  logic [15:0] quantum_q, quantum_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] saved_pc_q, saved_pc_d;
  logic        sys_pend_q, sys_pend_d;
  logic        tmr_pend_q, tmr_pend_d;
  logic        jump_q, jump_d;
  logic [15:0] jump_addr_q, jump_addr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        pc_out_valid_q, pc_out_valid_d;
  logic [15:0] dma_vec_q;
  logic        dma_pend_q;

  logic [3:0]  op_v;
  logic        op_sys, op_tmr, op_dma, op_start;
  logic        op_rtm, op_retr, op_pc;
  logic        st_idle, st_run, st_hnd;
  logic        disp;
  logic        win_sys, win_dma, win_tmr;
  logic        tmr_hit;
  logic        set_sys, set_tmr;
  logic [15:0] start_val;

  assign op_v     = SCHED_conf ? SCHED_OP : 4'h0;
  assign op_sys   = (op_v == 4'h1);
  assign op_tmr   = (op_v == 4'h2);
  assign op_dma   = (op_v == 4'h3);
  assign op_start = (op_v == 4'h4);
  assign op_rtm   = (op_v == 4'h5);
  assign op_retr  = (op_v == 4'h6);
  assign op_pc    = (op_v == 4'h7);

  assign st_idle = (state_q == IDLE);
  assign st_run  = (state_q == RUN);
  assign st_hnd  = (state_q == HANDLER);

  // Fixed priority: syscall, then DMA, then timer.
  assign win_sys = sys_pend_q;
  assign win_dma = ~sys_pend_q & dma_pend_q;
  assign win_tmr = ~sys_pend_q & ~dma_pend_q & tmr_pend_q;
  assign disp    = st_run & cpu_ready
                 & (sys_pend_q | dma_pend_q | tmr_pend_q);

  // RTimer suppresses the expiry check in the same cycle.
  assign tmr_hit = st_run & ~op_rtm
                 & (timer_q == quantum_q - 16'd1);

  // A zero vector masks its source.
  assign set_sys = syscall_req & ~st_idle & (sys_vec_q != 16'd0);
  assign set_tmr = tmr_hit & (tmr_vec_q != 16'd0);

  assign start_val = (SCHED_value == 16'd0) ? DEFAULT_QUANTUM
                                            : SCHED_value;

  always_comb begin
    state_d        = state_q;
    sys_vec_d      = sys_vec_q;
    tmr_vec_d      = tmr_vec_q;
    quantum_d      = quantum_q;
    timer_d        = timer_q;
    saved_pc_d     = saved_pc_q;
    jump_d         = 1'b0;
    jump_addr_d    = jump_addr_q;
    pc_out_d       = pc_out_q;
    pc_out_valid_d = 1'b0;

    if (op_sys) sys_vec_d = SCHED_value;
    if (op_tmr) tmr_vec_d = SCHED_value;
    if (op_start) quantum_d = start_val;

    if (op_rtm || tmr_hit) begin
      timer_d = 16'd0;
    end else if (st_run) begin
      timer_d = timer_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (op_start) begin
          timer_d = 16'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (disp) begin
          jump_d     = 1'b1;
          saved_pc_d = PC_pos;
          state_d    = HANDLER;
          unique case (1'b1)
            win_sys: jump_addr_d = sys_vec_q;
            win_dma: jump_addr_d = dma_vec_q;
            win_tmr: jump_addr_d = tmr_vec_q;
          endcase
        end
      end
      HANDLER: begin
        if (op_retr) begin
          jump_d      = 1'b1;
          jump_addr_d = saved_pc_q;
          timer_d     = 16'd0;
          state_d     = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    // A same-source request in the dispatch cycle re-arms the flag.
    sys_pend_d = (sys_pend_q & ~(disp & win_sys)) | set_sys;
    tmr_pend_d = (tmr_pend_q & ~(disp & win_tmr)) | set_tmr;

    if (op_pc) begin
      pc_out_d       = PC_pos;
      pc_out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      sys_vec_q      <= '0;
      tmr_vec_q      <= '0;
      quantum_q      <= '0;
      timer_q        <= '0;
      saved_pc_q     <= '0;
      sys_pend_q     <= 1'b0;
      tmr_pend_q     <= 1'b0;
      jump_q         <= 1'b0;
      jump_addr_q    <= '0;
      pc_out_q       <= '0;
      pc_out_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sys_vec_q      <= sys_vec_d;
      tmr_vec_q      <= tmr_vec_d;
      quantum_q      <= quantum_d;
      timer_q        <= timer_d;
      saved_pc_q     <= saved_pc_d;
      sys_pend_q     <= sys_pend_d;
      tmr_pend_q     <= tmr_pend_d;
      jump_q         <= jump_d;
      jump_addr_q    <= jump_addr_d;
      pc_out_q       <= pc_out_d;
      pc_out_valid_q <= pc_out_valid_d;
    end
  end

`ifdef SCHED_DMA_INT_EN
  logic [15:0] dma_vec_d;
  logic        dma_pend_d;
  logic        set_dma;

  assign set_dma = dma_irq & ~st_idle & (dma_vec_q != 16'd0);

  always_comb begin
    dma_vec_d  = dma_vec_q;
    if (op_dma) dma_vec_d = SCHED_value;
    dma_pend_d = (dma_pend_q & ~(disp & win_dma)) | set_dma;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dma_vec_q  <= '0;
      dma_pend_q <= 1'b0;
    end else begin
      dma_vec_q  <= dma_vec_d;
      dma_pend_q <= dma_pend_d;
    end
  end
`else
  // DMA source absent: request and vector op have no effect.
  logic unused_dma;
  assign unused_dma = dma_irq & op_dma;
  assign dma_vec_q  = '0;
  assign dma_pend_q = 1'b0;
`endif

  assign jump         = jump_q;
  assign jump_addr    = jump_addr_q;
  assign in_handler   = st_hnd;
  assign pc_out       = pc_out_q;
  assign pc_out_valid = pc_out_valid_q;

endmodule

// File: tb/tb_sched_controller.sv
// Self-checking bench for sched_controller: directed scenarios plus
// randomized traffic against a behavioural scheduler model.
module tb_sched_controller;

`ifdef SCHED_DMA_INT_EN
  localparam bit DmaEn = 1'b1;
`else
  localparam bit DmaEn = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HND  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        conf = 1'b0;
  logic [3:0]  sop = 4'h0;
  logic [15:0] sval = 16'h0;
  logic [15:0] pc = 16'h0;
  logic        rdy = 1'b1;
  logic        sreq = 1'b0;
  logic        dirq = 1'b0;
  logic        jump;
  logic [15:0] jump_addr;
  logic        in_handler;
  logic [15:0] pc_out;
  logic        pc_out_valid;

  int n_chk = 0;
  int n_err = 0;

  // Model: sources indexed 0=syscall, 1=dma, 2=timer (priority order).
  int          m_mode;
  logic [15:0] m_vec [3];
  bit   [2:0]  m_pend;
  logic [15:0] m_quant, m_timer, m_saved;
  bit          m_jump, m_pcv;
  logic [15:0] m_jaddr, m_pcout;

  sched_controller dut (
    .clk(clk), .reset(rst),
    .SCHED_conf(conf), .SCHED_OP(sop), .SCHED_value(sval),
    .PC_pos(pc), .cpu_ready(rdy),
    .syscall_req(sreq), .dma_irq(dirq),
    .jump(jump), .jump_addr(jump_addr), .in_handler(in_handler),
    .pc_out(pc_out), .pc_out_valid(pc_out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int          op, w, mode0;
    logic [15:0] t0;
    logic [15:0] v0 [3];
    bit   [2:0]  p0;
    bit          hit;
    if (rst) begin
      m_mode = M_IDLE; m_pend = '0;
      for (int s = 0; s < 3; s++) m_vec[s] = '0;
      m_quant = '0; m_timer = '0; m_saved = '0;
      m_jump = 0; m_pcv = 0; m_jaddr = '0; m_pcout = '0;
      return;
    end
    op = conf ? int'(sop) : 0;
    mode0 = m_mode; t0 = m_timer; p0 = m_pend;
    for (int s = 0; s < 3; s++) v0[s] = m_vec[s];
    m_jump = 0; m_pcv = 0; hit = 0; w = -1;
    if (mode0 == M_RUN && rdy && p0 != 0) begin
      for (int s = 0; s < 3; s++) if (p0[s] && w < 0) w = s;
      m_pend[w] = 0;
      m_jump = 1; m_jaddr = v0[w];
      m_saved = pc; m_mode = M_HND;
    end
    if (op == 5) m_timer = 16'd0;
    else if (mode0 == M_RUN) begin
      if (t0 == m_quant - 16'd1) begin
        m_timer = 16'd0; hit = 1;
      end else m_timer = t0 + 16'd1;
    end
    if (mode0 != M_IDLE) begin
      if (sreq && v0[0] != 0) m_pend[0] = 1;
      if (DmaEn && dirq && v0[1] != 0) m_pend[1] = 1;
    end
    if (hit && v0[2] != 0) m_pend[2] = 1;
    case (op)
      1: m_vec[0] = sval;
      2: m_vec[2] = sval;
      3: if (DmaEn) m_vec[1] = sval;
      4: begin
        m_quant = (sval == 0) ? 16'd1000 : sval;
        if (mode0 == M_IDLE) begin
          m_timer = 16'd0; m_mode = M_RUN;
        end
      end
      6: if (mode0 == M_HND) begin
        m_jump = 1; m_jaddr = m_saved;
        m_timer = 16'd0; m_mode = M_RUN;
      end
      7: begin m_pcout = pc; m_pcv = 1; end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("jump", jump, m_jump);
    if (m_jump) chk("jump_addr", jump_addr, m_jaddr);
    chk("in_handler", in_handler, m_mode == M_HND);
    chk("pc_out", pc_out, m_pcout);
    chk("pc_out_valid", pc_out_valid, m_pcv);
    @(negedge clk);
    conf = 0; sreq = 0; dirq = 0;
  endtask

  task automatic op(input logic [3:0] o, input logic [15:0] v);
    conf = 1; sop = o; sval = v;
    tick();
  endtask

  task automatic wait_jump(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (jump) begin n = i; break; end
    end
  endtask

  initial begin
    int n, cnt, r;
    rst = 1;
    tick();
    chk("rst_jump", jump, 0);
    chk("rst_jaddr", jump_addr, 0);
    chk("rst_inh", in_handler, 0);
    chk("rst_pcout", pc_out, 0);
    chk("rst_pcv", pc_out_valid, 0);
    rst = 0;

    // Default quantum via Start 0.
    op(4'h2, 16'h0200);
    op(4'h4, 16'h0000);
    wait_jump(1100, n);
    chk("tmr_latency", n, 1001);
    chk("tmr_addr", jump_addr, 16'h0200);
    chk("tmr_inh", in_handler, 1);
    op(4'h6, 16'h0);

    // Syscall dispatch and return.
    pc = 16'h0040;
    op(4'h1, 16'h0100);
    sreq = 1; tick();
    wait_jump(5, n);
    chk("sys_latency", n, 1);
    chk("sys_addr", jump_addr, 16'h0100);
    op(4'h6, 16'h0);
    chk("retr_jump", jump, 1);
    chk("retr_addr", jump_addr, 16'h0040);
    chk("retr_inh", in_handler, 0);

    // Simultaneous syscall and DMA.
    op(4'h3, 16'h0300);
    sreq = 1; dirq = 1; tick();
    wait_jump(5, n);
    chk("both_first", jump_addr, 16'h0100);
    op(4'h6, 16'h0);
    wait_jump(5, n);
    chk("dma_after_retr", n, DmaEn ? 1 : -1);
    if (m_mode == M_HND) op(4'h6, 16'h0);

    // Masked DMA and RETR in RUN.
    op(4'h3, 16'h0000);
    dirq = 1; tick();
    wait_jump(5, n);
    chk("dma_masked", n, -1);
    op(4'h6, 16'h0);
    chk("retr_in_run", jump, 0);

    // RTimer on the expiry cycle, then cpu_ready stall.
    rst = 1; tick(); rst = 0;
    op(4'h2, 16'h0200);
    op(4'h4, 16'd5);
    for (int i = 0; i < 4; i++) tick();
    op(4'h5, 16'h0);
    wait_jump(20, n);
    chk("rtimer_next", n, 6);
    op(4'h6, 16'h0);
    rdy = 0; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (jump) cnt++;
    end
    chk("stall_nojump", cnt, 0);
    rdy = 1;
    wait_jump(3, n);
    chk("stall_release", n, 1);
    op(4'h6, 16'h0);

    // PC capture.
    pc = 16'h1234;
    op(4'h7, 16'h0);
    chk("pc_cap", pc_out, 16'h1234);
    chk("pc_valid", pc_out_valid, 1);
    tick();
    chk("pc_valid_drop", pc_out_valid, 0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      conf = 1; sval = 16'($urandom);
      if (r < 10) sop = 4'h6;
      else if (r < 12) sop = 4'h5;
      else if (r < 15) begin
        sop = 4'h4; sval = 16'($urandom_range(0, 40));
      end
      else if (r < 17) sop = 4'h1;
      else if (r < 19) sop = 4'h2;
      else if (r < 21) sop = 4'h3;
      else if (r < 24) sop = 4'h7;
      else if (r < 26) sop = ($urandom_range(0, 1) == 0) ? 4'h0
                          : 4'($urandom_range(8, 15));
      else conf = 0;
      if ((sop == 4'h1 || sop == 4'h2 || sop == 4'h3)
          && $urandom_range(0, 4) == 0) sval = 16'h0;
      sreq = ($urandom_range(0, 14) == 0);
      dirq = ($urandom_range(0, 14) == 0);
      rdy  = ($urandom_range(0, 7) != 0);
      pc   = 16'($urandom);
      rst  = ($urandom_range(0, 499) == 0);
      tick();
      rst = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
